// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the FSM state encoding and the index wrap used by the round-robin search.
package fifo_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   // Single-step wrap; callers never pass idx >= 2*n.
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: finds the first set request bit at or after ptr, wrapping upward.
// Purely combinational; found is high whenever any request is present.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            found,
   output logic [IW-1:0]   idx
);

   logic [IW-1:0] cand;

   // Scan from the farthest offset down so the nearest hit to ptr is written last.
   always_comb begin
      idx  = '0;
      cand = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = IW'(rr_wrap(int'(ptr) + k, NREQ));
         if (req[cand]) idx = cand;
      end
   end

   assign found = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Grants are bounded to MAX_BURST writes and always end with a single IDLE cycle.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     din_flat,
   output logic [NREQ-1:0]           ack,
   output logic [WIDTH-1:0]          fifo_din,
   output logic                      fifo_wr_en,
   input  logic                      fifo_full,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      busy
);

   localparam int IW = $clog2(NREQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   arb_state_t    state;
   logic [IW-1:0] rr_ptr;
   logic [BW-1:0] burst_cnt;
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic          req_g;
   logic          wr;
   logic          last_beat;
   logic [IW-1:0] next_ptr;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Handshake: req[i] acts as valid with data on slice i; ack[i] is the ready/transfer
   // strobe, so a word moves exactly in cycles where req[i] & ack[i], and the producer
   // may only change its slice after such a cycle.
   assign req_g      = req[grant_id];
   assign wr         = (state == ARB_GRANT) && req_g && !fifo_full && !rst;
   assign fifo_wr_en = wr;
   assign ack        = wr ? (NREQ'(1) << grant_id) : '0;
   assign fifo_din   = din_flat[int'(grant_id)*WIDTH +: WIDTH];
   assign busy       = (state == ARB_GRANT);
   assign last_beat  = (burst_cnt == BW'(MAX_BURST - 1));
   assign next_ptr   = IW'(rr_wrap(int'(grant_id) + 1, NREQ));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         rr_ptr    <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
      end else if (state == ARB_IDLE) begin
         if (pick_found) begin
            grant_id  <= pick_idx;
            burst_cnt <= '0;
            state     <= ARB_GRANT;
         end
      end else begin
         if (wr) burst_cnt <= burst_cnt + BW'(1);
         // Release on a dropped request (even while stalled) or on the final beat.
         if (!req_g || (wr && last_beat)) begin
            state  <= ARB_IDLE;
            rr_ptr <= next_ptr;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random bench for fifo_wr_arbiter with an expected-word scoreboard.
// Producer data encodes {producer id, sequence number} so order and source are both visible.
module tb_fifo_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] din_flat;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      fifo_din;
   logic                  fifo_wr_en;
   logic                  fifo_full;
   logic [1:0]            grant_id;
   logic                  busy;

   fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .din_flat   (din_flat),
      .ack        (ack),
      .fifo_din   (fifo_din),
      .fifo_wr_en (fifo_wr_en),
      .fifo_full  (fifo_full),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int               passed = 0;
   int               total  = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [5:0]       seq[NREQ];
   logic [5:0]       exp_seq[NREQ];
   bit               use_q;
   int               burst_run;

   logic [NREQ-1:0]  s_ack;
   logic             s_busy;
   logic [1:0]       s_gid;
   logic             s_wr;
   logic [WIDTH-1:0] s_din;

   function automatic logic [WIDTH-1:0] word(input int i, input logic [5:0] s);
      return {i[1:0], s};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic drive_din();
      for (int i = 0; i < NREQ; i++) din_flat[i*WIDTH +: WIDTH] = word(i, seq[i]);
   endtask

   task automatic expect_words(input int p, input int n);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(word(p, exp_seq[p]));
         exp_seq[p]++;
      end
   endtask

   // One clock cycle: sample at negedge, producers advance after the posedge.
   task automatic tick();
      @(negedge clk);
      s_ack  = ack;
      s_busy = busy;
      s_gid  = grant_id;
      s_wr   = fifo_wr_en;
      s_din  = fifo_din;
      check("ack_onehot", 32'(ack), fifo_wr_en ? (32'd1 << grant_id) : 32'd0);
      if (fifo_wr_en) begin
         if (use_q) begin
            if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else check("wdata", 32'(fifo_din), 32'(exp_q.pop_front()));
         end else begin
            check("rnd_din", 32'(fifo_din), 32'(word(int'(grant_id), seq[grant_id])));
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (s_ack[i]) seq[i]++;
      drive_din();
   endtask

   // ---------------- stimulus ----------------
   int order[6] = '{0, 1, 3, 0, 1, 3};

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         seq[i]     = '0;
         exp_seq[i] = '0;
      end
      use_q     = 1'b1;
      burst_run = 0;
      rst       = 1'b1;
      req       = 4'b1111;
      fifo_full = 1'b0;
      drive_din();

      // Reset held 3 cycles with all requests high.
      for (int k = 0; k < 3; k++) begin
         tick();
         check("rst_busy", 32'(s_busy), 32'd0);
         check("rst_ack", 32'(s_ack), 32'd0);
         check("rst_wr", 32'(s_wr), 32'd0);
         check("rst_din", 32'(s_din), 32'(word(0, 6'd0)));
      end
      rst = 1'b0;
      tick();
      check("first_idle", 32'(s_busy), 32'd0);
      expect_words(0, 1);
      tick();
      check("first_busy", 32'(s_busy), 32'd1);
      check("first_gid", 32'(s_gid), 32'd0);
      check("first_wr", 32'(s_wr), 32'd1);
      req = 4'b0000;
      tick();
      check("drop_nowr", 32'(s_wr), 32'd0);
      tick();

      // Burst limit: lone requester 2 gets 4 beats then one bubble.
      req = 4'b0100;
      expect_words(2, 8);
      for (int k = 0; k < 10; k++) begin
         tick();
         check("burst_ack", 32'(s_ack), (k % 5 == 0) ? 32'd0 : 32'd4);
      end
      req = 4'b0000;
      tick();

      // Rotation from rr_ptr = 0 with req = 1011.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b1011;
      for (int g = 0; g < 6; g++) expect_words(order[g], 4);
      for (int k = 0; k < 30; k++) begin
         tick();
         if (k % 5 == 0) check("rot_idle", 32'(s_busy), 32'd0);
         else            check("rot_gid", 32'(s_gid), 32'(order[k/5]));
      end
      req = 4'b0000;
      tick();
      req = 4'b1111;
      expect_words(0, 1);
      tick();
      tick();
      check("rr_after_3", 32'(s_gid), 32'd0);
      req = 4'b0000;
      tick();
      tick();

      // Full stall in the middle of producer 1's grant.
      req = 4'b0010;
      expect_words(1, 4);
      tick();
      tick();
      tick();
      check("stall_pre_wr", 32'(s_wr), 32'd1);
      fifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_ack", 32'(s_ack), 32'd0);
         check("stall_gid", 32'(s_gid), 32'd1);
         check("stall_busy", 32'(s_busy), 32'd1);
      end
      fifo_full = 1'b0;
      tick();
      check("stall_post_wr", 32'(s_wr), 32'd1);
      tick();
      check("stall_post_wr", 32'(s_wr), 32'd1);
      req = 4'b0000;
      tick();
      check("stall_done_idle", 32'(s_busy), 32'd0);
      check("stall_q_empty", 32'(exp_q.size()), 32'd0);

      // Early release: producer 0 quits after 2 writes, producer 1 is next.
      req = 4'b0011;
      expect_words(0, 2);
      tick();
      tick();
      check("early_gid0", 32'(s_gid), 32'd0);
      tick();
      req = 4'b0010;
      tick();
      check("early_drop_busy", 32'(s_busy), 32'd1);
      check("early_drop_nowr", 32'(s_wr), 32'd0);
      tick();
      check("early_idle", 32'(s_busy), 32'd0);
      expect_words(1, 1);
      tick();
      check("early_next", 32'(s_gid), 32'd1);
      req = 4'b0000;
      tick();
      tick();

      // Reset on the third beat of producer 2's grant.
      req = 4'b0100;
      expect_words(2, 2);
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("rst_mid_wr", 32'(s_wr), 32'd0);
      check("rst_mid_ack", 32'(s_ack), 32'd0);
      rst = 1'b0;
      req = 4'b0000;
      tick();
      check("rst_mid_idle", 32'(s_busy), 32'd0);
      req = 4'b1111;
      expect_words(0, 1);
      tick();
      tick();
      check("rst_mid_ptr", 32'(s_gid), 32'd0);
      req = 4'b0000;
      tick();
      tick();
      check("q_empty", 32'(exp_q.size()), 32'd0);

      // Random traffic with random FIFO backpressure.
      use_q = 1'b0;
      for (int k = 0; k < 300; k++) begin
         req       = 4'($urandom_range(0, 15));
         fifo_full = ($urandom_range(0, 3) == 0);
         tick();
         if (s_busy) begin
            check("rnd_wr", 32'(s_wr), 32'(req[s_gid] & ~fifo_full));
            if (s_wr) begin
               burst_run++;
               check("rnd_burst_max", 32'(burst_run <= MAX_BURST), 32'd1);
            end
         end else begin
            burst_run = 0;
            check("rnd_idle_wr", 32'(s_wr), 32'd0);
         end
      end
      req       = 4'b0000;
      fifo_full = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
